decoder_in_conditioner: RTL and testbench

//   Upstream stage of the decoder: conditions the raw 7-bit io_in pad bus before decoding.

---
 rtl/decoder_proj_pkg.sv | 17 +
 rtl/decoder_in_sync.sv | 32 +++
 rtl/decoder_in_conditioner.sv | 146 ++++++++++++++
 tb/tb_decoder_in_conditioner.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_proj_pkg.sv
// Shared definitions for the decoder input path.
//   DEC_IO_W           default pad bus / code width
//   DEC_STABLE_CYCLES  default debounce depth (identical synced samples required)
//   DEC_CNT_W          default debounce counter width
//   dec_state_e        conditioner FSM encoding (StSettle = 0, StOffer = 1)
package decoder_proj_pkg;

    localparam int unsigned DEC_IO_W          = 7;
    localparam int unsigned DEC_STABLE_CYCLES = 4;
    localparam int unsigned DEC_CNT_W         = 3;

    typedef enum logic {
        StSettle = 1'b0,
        StOffer  = 1'b1
    } dec_state_e;

endpackage

// File: rtl/decoder_in_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
// Ports:
//   clk    in   1      destination clock
//   rst_n  in   1      async active-low reset, clears both stages
//   d      in   WIDTH  asynchronous input bus
//   q      out  WIDTH  synchronised bus (two clocks of latency)
module decoder_in_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Nothing may sit between the two stages, so they share one process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/decoder_in_conditioner.sv
// Conditions the raw pad bus for the decoder: synchronise, debounce, and offer
// each new stable code exactly once over a valid/ready handshake.
// Optional feature macro: DEC_IN_COND_STATS_EN adds change_cnt_o, a 16-bit
// wrapping count of completed transfers (cleared by clr_i).
// Ports:
//   clk           in   1     system clock
//   rst_n         in   1     async active-low reset
//   io_in         in   IO_W  raw pad inputs, asynchronous to clk
//   code_o        out  IO_W  debounced code offered to the decoder
//   code_valid_o  out  1     code_o valid
//   code_ready_i  in   1     decoder accepts code_o
//   overrun_o     out  1     sticky: a new stable code appeared while an offer was pending
//   clr_i         in   1     sync clear of overrun_o (and change_cnt_o if built)
//   change_cnt_o  out  16    completed transfer count (DEC_IN_COND_STATS_EN only)
module decoder_in_conditioner
    import decoder_proj_pkg::*;
#(
    parameter int unsigned IO_W          = DEC_IO_W,
    parameter int unsigned STABLE_CYCLES = DEC_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEC_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IO_W-1:0] io_in,
    output logic [IO_W-1:0] code_o,
    output logic            code_valid_o,
    input  logic            code_ready_i,
    output logic            overrun_o,
`ifdef DEC_IN_COND_STATS_EN
    output logic [15:0]     change_cnt_o,
`endif
    input  logic            clr_i
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    logic [IO_W-1:0]  s2;
    logic [IO_W-1:0]  cand_q;
    logic [IO_W-1:0]  last_q;
    logic [IO_W-1:0]  code_q;
    logic [CNT_W-1:0] cnt_q;
    logic             have_last_q;
    logic             overrun_q;
    dec_state_e       state_q;
    dec_state_e       state_d;
    logic             stable;
    logic             fresh;
    logic             transfer;

    decoder_in_sync #(
        .WIDTH (IO_W)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (io_in),
        .q     (s2)
    );

    // Debounce: any change restarts the count; the counter saturates at CntMax.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else if (s2 != cand_q) begin
            cand_q <= s2;
            cnt_q  <= '0;
        end else if (cnt_q < CntMax) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stable   = (s2 == cand_q) && (cnt_q == CntMax);
    // Right after reset nothing has been offered yet, so any stable value counts.
    assign fresh    = stable && (!have_last_q || (cand_q != last_q));
    assign transfer = code_valid_o && code_ready_i;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StSettle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSettle: if (fresh)    state_d = StOffer;
            StOffer:  if (transfer) state_d = StSettle;
            default:                state_d = StSettle;
        endcase
    end

    // FSM outputs: valid is exactly "in OFFER", so reset drops it asynchronously.
    always_comb begin
        code_valid_o = (state_q == StOffer);
    end

    // Capture the offered code; it stays frozen for the whole OFFER state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q      <= '0;
            last_q      <= '0;
            have_last_q <= 1'b0;
        end else if ((state_q == StSettle) && fresh) begin
            code_q      <= cand_q;
            last_q      <= cand_q;
            have_last_q <= 1'b1;
        end
    end

    // A fresh value while an offer is stuck is an overrun; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if ((state_q == StOffer) && fresh && !transfer) begin
            overrun_q <= 1'b1;
        end else if (clr_i) begin
            overrun_q <= 1'b0;
        end
    end

    assign code_o    = code_q;
    assign overrun_o = overrun_q;

`ifdef DEC_IN_COND_STATS_EN
    logic [15:0] change_cnt_q;

    // Clear beats a simultaneous transfer; the count wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change_cnt_q <= '0;
        end else if (clr_i) begin
            change_cnt_q <= '0;
        end else if (transfer) begin
            change_cnt_q <= change_cnt_q + 16'd1;
        end
    end

    assign change_cnt_o = change_cnt_q;
`else
`endif

endmodule

// File: tb/tb_decoder_in_conditioner.sv
module tb_decoder_in_conditioner;

    logic       clk;
    logic       rst_n;
    logic [6:0] io_in;
    logic [6:0] code_o;
    logic       code_valid_o;
    logic       code_ready_i;
    logic       overrun_o;
    logic       clr_i;
`ifdef DEC_IN_COND_STATS_EN
    logic [15:0] change_cnt_o;
`endif

    int errors;
    int checks;

    decoder_in_conditioner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_in        (io_in),
        .code_o       (code_o),
        .code_valid_o (code_valid_o),
        .code_ready_i (code_ready_i),
        .overrun_o    (overrun_o),
`ifdef DEC_IN_COND_STATS_EN
        .change_cnt_o (change_cnt_o),
`endif
        .clr_i        (clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helper only: waits (bounded) at negedges until valid rises.
    task automatic wait_valid(input int max_cycles, output int n);
        n = 0;
        while ((code_valid_o !== 1'b1) && (n < max_cycles)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        io_in        = 7'b1111011;
        code_ready_i = 1'b1;
        clr_i        = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (code_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", code_valid_o);
        end
        checks++;
        if (code_o !== 7'h00) begin
            errors++; $display("FAIL reset_code: got %h want 00", code_o);
        end
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++; $display("FAIL reset_overrun: got %b want 0", overrun_o);
        end
`ifdef DEC_IN_COND_STATS_EN
        checks++;
        if (change_cnt_o !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", change_cnt_o);
        end
`endif
        rst_n = 1'b1;
        // Edges 0..5 after release: not yet valid.
        repeat (6) @(negedge clk);
        checks++;
        if (code_valid_o !== 1'b0) begin
            errors++; $display("FAIL first_latency_early: got %b want 0 at edge 5", code_valid_o);
        end
        @(negedge clk);
        checks++;
        if (code_valid_o !== 1'b1) begin
            errors++; $display("FAIL first_latency: got %b want 1 at edge 6", code_valid_o);
        end
        checks++;
        if (code_o !== 7'h7B) begin
            errors++; $display("FAIL first_code: got %h want 7b", code_o);
        end
        @(negedge clk);
        checks++;
        if (code_valid_o !== 1'b0) begin
            errors++; $display("FAIL first_pulse: got %b want 0", code_valid_o);
        end
        begin
            int offers;
            offers = 0;
            repeat (12) begin
                @(negedge clk);
                if (code_valid_o === 1'b1) offers++;
            end
            checks++;
            if (offers !== 0) begin
                errors++; $display("FAIL first_no_reoffer: got %0d offers want 0", offers);
            end
        end
    endtask

    task automatic test_bounce;
        int offers;
        logic [6:0] seen;
        offers = 0;
        for (int i = 0; i < 10; i++) begin
            io_in = (i % 2 == 0) ? 7'h00 : 7'h7B;
            repeat (2) begin
                @(negedge clk);
                if (code_valid_o === 1'b1) offers++;
            end
        end
        checks++;
        if (offers !== 0) begin
            errors++; $display("FAIL bounce_quiet: got %0d offers want 0", offers);
        end
        io_in  = 7'h00;
        offers = 0;
        seen   = 7'h7F;
        repeat (20) begin
            @(negedge clk);
            if (code_valid_o === 1'b1) begin
                offers++;
                seen = code_o;
            end
        end
        checks++;
        if (offers !== 1) begin
            errors++; $display("FAIL bounce_single_offer: got %0d offers want 1", offers);
        end
        checks++;
        if (seen !== 7'h00) begin
            errors++; $display("FAIL bounce_code: got %h want 00", seen);
        end
    endtask

    task automatic test_overrun;
        int n;
        code_ready_i = 1'b0;
        io_in        = 7'h01;
        repeat (10) @(negedge clk);
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++; $display("FAIL ovr_before: got %b want 0", overrun_o);
        end
        io_in = 7'h02;
        repeat (10) @(negedge clk);
        checks++;
        if ((code_valid_o !== 1'b1) || (code_o !== 7'h01)) begin
            errors++; $display("FAIL ovr_frozen: got valid=%b code=%h want valid=1 code=01",
                               code_valid_o, code_o);
        end
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++; $display("FAIL ovr_set: got %b want 1", overrun_o);
        end
        code_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (code_valid_o !== 1'b0) begin
            errors++; $display("FAIL ovr_gap: got %b want 0", code_valid_o);
        end
        @(negedge clk);
        checks++;
        if ((code_valid_o !== 1'b1) || (code_o !== 7'h02)) begin
            errors++; $display("FAIL ovr_pending: got valid=%b code=%h want valid=1 code=02",
                               code_valid_o, code_o);
        end
        @(negedge clk);
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++; $display("FAIL ovr_sticky: got %b want 1", overrun_o);
        end
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++; $display("FAIL ovr_clear: got %b want 0", overrun_o);
        end
        // Clear held across a new overrun event: set must win.
        code_ready_i = 1'b0;
        io_in        = 7'h10;
        wait_valid(20, n);
        checks++;
        if (code_valid_o !== 1'b1) begin
            errors++; $display("FAIL setwin_offer: got valid=%b after %0d cycles want 1",
                               code_valid_o, n);
        end
        clr_i = 1'b1;
        io_in = 7'h20;
        repeat (10) @(negedge clk);
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++; $display("FAIL setwin_overrun: got %b want 1", overrun_o);
        end
        clr_i        = 1'b0;
        code_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ((code_valid_o !== 1'b1) || (code_o !== 7'h20)) begin
            errors++; $display("FAIL setwin_pending: got valid=%b code=%h want valid=1 code=20",
                               code_valid_o, code_o);
        end
        @(negedge clk);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
    endtask

    task automatic test_same_value;
        int n;
        int offers;
        io_in = 7'h7B;
        wait_valid(20, n);
        checks++;
        if ((code_valid_o !== 1'b1) || (code_o !== 7'h7B)) begin
            errors++; $display("FAIL same_first: got valid=%b code=%h want valid=1 code=7b",
                               code_valid_o, code_o);
        end
        @(negedge clk);
        io_in = 7'h00;
        repeat (2) @(negedge clk);
        io_in  = 7'h7B;
        offers = 0;
        repeat (20) begin
            @(negedge clk);
            if (code_valid_o === 1'b1) offers++;
        end
        checks++;
        if (offers !== 0) begin
            errors++; $display("FAIL same_no_reoffer: got %0d offers want 0", offers);
        end
    endtask

    task automatic test_reset_mid_offer;
        int n;
        code_ready_i = 1'b0;
        io_in        = 7'h55;
        wait_valid(20, n);
        checks++;
        if (code_valid_o !== 1'b1) begin
            errors++; $display("FAIL rst_pre_offer: got %b want 1", code_valid_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (code_valid_o !== 1'b0) begin
            errors++; $display("FAIL rst_async_valid: got %b want 0", code_valid_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (code_valid_o !== 1'b0) begin
            errors++; $display("FAIL rst_reoffer_early: got %b want 0", code_valid_o);
        end
        @(negedge clk);
        checks++;
        if ((code_valid_o !== 1'b1) || (code_o !== 7'h55)) begin
            errors++; $display("FAIL rst_reoffer: got valid=%b code=%h want valid=1 code=55",
                               code_valid_o, code_o);
        end
        code_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (code_valid_o !== 1'b0) begin
            errors++; $display("FAIL rst_drain: got %b want 0", code_valid_o);
        end
    endtask

`ifdef DEC_IN_COND_STATS_EN
    task automatic test_stats;
        int n;
        logic [6:0] vals [3];
        vals[0] = 7'h11;
        vals[1] = 7'h22;
        vals[2] = 7'h33;
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        checks++;
        if (change_cnt_o !== 16'd0) begin
            errors++; $display("FAIL stats_clear0: got %0d want 0", change_cnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            io_in = vals[i];
            wait_valid(20, n);
            @(negedge clk);
        end
        checks++;
        if (change_cnt_o !== 16'd3) begin
            errors++; $display("FAIL stats_three: got %0d want 3", change_cnt_o);
        end
        io_in = 7'h44;
        wait_valid(20, n);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        checks++;
        if ((change_cnt_o !== 16'd0) || (code_valid_o !== 1'b0)) begin
            errors++; $display("FAIL stats_xfer_clr: got cnt=%0d valid=%b want cnt=0 valid=0",
                               change_cnt_o, code_valid_o);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_bounce();
        test_overrun();
        test_same_value();
        test_reset_mid_offer();
`ifdef DEC_IN_COND_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
